// File: rtl/match_event_monitor.sv
// Match event monitor: counts detector matches, measures inter-match gaps into a
// one-entry valid/ready buffer, and flags bursts of matches in fixed windows.
module match_event_monitor #(
    parameter int CNT_W    = 16,
    parameter int GAP_W    = 8,
    parameter int WINDOW   = 16,
    parameter int BURST_TH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             match,
    input  logic             clr,
    input  logic             gap_ready,
    output logic [CNT_W-1:0] total_cnt,
    output logic             gap_valid,
    output logic [GAP_W-1:0] gap_data,
    output logic [GAP_W-1:0] min_gap,
    output logic             active,
    output logic             burst,
    output logic             ovf
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WM_W  = $clog2(BURST_TH + 1);

    typedef enum logic {
        S_IDLE,
        S_TRACK
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_total_cnt, w_total_cnt_next;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic               r_gap_valid, w_gap_valid_next;
    logic [GAP_W-1:0]   r_gap_data, w_gap_data_next;
    logic [GAP_W-1:0]   r_min_gap, w_min_gap_next;
    logic [WIN_W-1:0]   r_win_cnt, w_win_cnt_next;
    logic [WM_W-1:0]    r_win_matches, w_win_matches_next;
    logic               r_burst, w_burst_next;
    logic               r_ovf, w_ovf_next;

    logic               w_report;
    logic               w_buf_free;
    logic               w_win_close;
    logic [WM_W:0]      w_win_sum;

    assign w_buf_free  = !r_gap_valid || gap_ready;
    assign w_win_close = (r_win_cnt == WIN_W'(WINDOW - 1));
    // One bit wider so a match in the closing cycle on top of a saturated count cannot wrap.
    assign w_win_sum   = {1'b0, r_win_matches} + {{WM_W{1'b0}}, match};

    always_comb begin
        w_state_next       = r_state;
        w_total_cnt_next   = r_total_cnt;
        w_gap_cnt_next     = r_gap_cnt;
        w_gap_valid_next   = r_gap_valid;
        w_gap_data_next    = r_gap_data;
        w_min_gap_next     = r_min_gap;
        w_win_cnt_next     = r_win_cnt;
        w_win_matches_next = r_win_matches;
        w_burst_next       = r_burst;
        w_ovf_next         = r_ovf;
        w_report           = 1'b0;

        if (clr) begin
            w_state_next       = S_IDLE;
            w_total_cnt_next   = '0;
            w_gap_cnt_next     = '0;
            w_gap_valid_next   = 1'b0;
            w_gap_data_next    = '0;
            w_min_gap_next     = '1;
            w_win_cnt_next     = '0;
            w_win_matches_next = '0;
            w_burst_next       = 1'b0;
            w_ovf_next         = 1'b0;
        end else begin
            if (match && (r_total_cnt != '1)) begin
                w_total_cnt_next = r_total_cnt + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    w_gap_cnt_next = '0;
                    if (match) begin
                        w_state_next   = S_TRACK;
                        w_gap_cnt_next = GAP_W'(1);
                    end
                end
                S_TRACK: begin
                    if (match) begin
                        w_report       = 1'b1;
                        w_gap_cnt_next = GAP_W'(1);
                    end else if (r_gap_cnt != '1) begin
                        w_gap_cnt_next = r_gap_cnt + 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase

            // Dropped reports still contribute to min_gap.
            if (w_report) begin
                if (r_gap_cnt < r_min_gap) begin
                    w_min_gap_next = r_gap_cnt;
                end
                if (w_buf_free) begin
                    w_gap_valid_next = 1'b1;
                    w_gap_data_next  = r_gap_cnt;
                end else begin
                    w_ovf_next = 1'b1;
                end
            end else if (r_gap_valid && gap_ready) begin
                w_gap_valid_next = 1'b0;
            end

            if (w_win_close) begin
                if (w_win_sum >= (WM_W + 1)'(BURST_TH)) begin
                    w_burst_next = 1'b1;
                end
                w_win_matches_next = '0;
                w_win_cnt_next     = '0;
            end else begin
                w_win_cnt_next = r_win_cnt + 1'b1;
                if (match && (r_win_matches != WM_W'(BURST_TH))) begin
                    w_win_matches_next = r_win_matches + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_total_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_gap_valid   <= 1'b0;
            r_gap_data    <= '0;
            r_min_gap     <= '1;
            r_win_cnt     <= '0;
            r_win_matches <= '0;
            r_burst       <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_total_cnt   <= w_total_cnt_next;
            r_gap_cnt     <= w_gap_cnt_next;
            r_gap_valid   <= w_gap_valid_next;
            r_gap_data    <= w_gap_data_next;
            r_min_gap     <= w_min_gap_next;
            r_win_cnt     <= w_win_cnt_next;
            r_win_matches <= w_win_matches_next;
            r_burst       <= w_burst_next;
            r_ovf         <= w_ovf_next;
        end
    end

    assign total_cnt = r_total_cnt;
    assign gap_valid = r_gap_valid;
    assign gap_data  = r_gap_data;
    assign min_gap   = r_min_gap;
    assign active    = (r_state == S_TRACK);
    assign burst     = r_burst;
    assign ovf       = r_ovf;

endmodule

// File: doc/match_event_monitor.md
Name: match_event_monitor

Overview:
Sits directly downstream of the serial pattern detector and consumes its 1-bit match output. It keeps a saturating count of all matches and measures the gap in cycles between consecutive matches. Gap reports are delivered through a one-entry valid/ready buffer. The block also flags bursts of matches within fixed-length windows and exposes sticky status for software and bench checking.

Parameters:
CNT_W, 16, width of the total match counter (saturating)
GAP_W, 8, width of the gap counter, gap report and min_gap (saturating)
WINDOW, 16, burst-window length in cycles (≥2); window counter width is $clog2(WINDOW)
BURST_TH, 4, matches per window at or above which burst is set

Ports:
clk  input  1  system clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
match  input  1  detector output; every cycle sampled high counts as one match
clr  input  1  synchronous clear of all state
gap_ready  input  1  consumer accepts gap report
total_cnt  output  CNT_W  matches since reset/clr, saturating
gap_valid  output  1  gap report buffer holds data
gap_data  output  GAP_W  cycles between the last two matches
min_gap  output  GAP_W  smallest gap reported since reset/clr
active  output  1  high once the first match has been seen (TRACK state)
burst  output  1  sticky: some window reached BURST_TH matches
ovf  output  1  sticky: a gap report was dropped because the buffer was full

Behaviour:
- Reset (rstn low, async): total_cnt=0, gap_valid=0, gap_data=0, min_gap=all ones, active=0, burst=0, ovf=0. Internal state: FSM=IDLE, gap_cnt=0, win_cnt=0, win_matches=0. A reset asserted mid-operation discards everything immediately.
- All outputs are registered. The effect of a match in cycle t is visible in cycle t+1.
- total_cnt: increments on each cycle with match=1 and holds at 2^CNT_W-1.
- FSM IDLE: gap_cnt is held at 0. A match moves the FSM to TRACK with gap_cnt<=1 and generates no report.
- FSM TRACK:
  - Cycle without a match: gap_cnt increments, saturating at 2^GAP_W-1.
  - Cycle with a match: generates report value gap_cnt, then gap_cnt<=1.
  - Consecutive match cycles report gap 1. A match at t followed by a match at t+3 reports 3.
  - TRACK exits only on clr or reset.
- Report buffer (1 entry):
  - Report generated and (gap_valid=0 or gap_valid&gap_ready): load gap_data and set gap_valid=1.
  - Report generated and gap_valid=1 and gap_ready=0: report dropped, gap_data unchanged, ovf<=1.
  - No report and gap_valid&gap_ready: gap_valid<=0 and gap_data holds its last value.
  - gap_data is stable while gap_valid=1 and gap_ready=0.
- min_gap: on every generated report, including dropped ones, min_gap<=min(min_gap, report).
- Windows:
  - win_cnt runs 0..WINDOW-1 continuously from reset/clr and wraps.
  - win_matches counts match cycles and saturates at BURST_TH.
  - In the cycle where win_cnt==WINDOW-1: if win_matches+match ≥ BURST_TH, then burst<=1; win_matches<=0.
  - A match in the last cycle counts toward the closing window.
- clr (synchronous) has priority over everything except rstn. It applies the reset values to all outputs and state. A match in the same cycle is ignored (not counted, no report, no state change). gap_ready is ignored that cycle.
- burst and ovf clear only via rstn or clr.

Test Plan:
1. rstn=0 for 5 cycles, then release with match=0 for 20 cycles -> total_cnt=0, gap_valid=0, min_gap=0xFF, active=0, burst=0, ovf=0 throughout.
2. gap_ready=1, match pulses at cycles 10, 13, 14 -> active=1 from cycle 11; total_cnt=3 at cycle 15; gap_valid high at cycle 14 (data 3) and cycle 15 (data 1); min_gap=1; ovf=0.
3. gap_ready=0, matches at cycles 10, 12, 15 -> gap_data=2 held from cycle 13; report 3 dropped, ovf=1 at cycle 16, min_gap=2; then gap_ready=1 for one cycle -> gap_valid=0 the next cycle.
4. WINDOW=16, BURST_TH=4: 3 matches in window 0 -> burst=0; 4 matches in window 1, the last one in that window's final cycle -> burst=1 one cycle after the window closes, and it stays high.
5. Saturation: GAP_W=8 with a 300-cycle gap -> gap_data=255. CNT_W=4 with 20 matches -> total_cnt=15.
6. clr in the same cycle as a match while in TRACK -> next cycle all outputs at reset values and the match is not counted; the following match reports nothing; rstn pulsed mid-gap -> immediate reset values.
